// File: rtl/id_ex_stage_if.sv
// Bundle between IF/ID, writeback and the ID/EX stage: decode inputs, regfile write port and EX outputs.
// master drives instructions and writeback; slave is the ID/EX stage itself.
interface id_ex_stage_if;
  logic [7:0] instr_ID;
  logic [7:0] PC_ID;
  logic       valid_ID;
  logic       stall;
  logic       flush;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;

  logic [7:0] A_in;
  logic [7:0] Imm_Data_EX;
  logic [7:0] Sht_Data_EX;
  logic [7:0] PC_EX;
  logic [1:0] opcode_EX;
  logic [3:0] ControlLines;
  logic       sht_imm;
  logic [2:0] rd_EX;
  logic       valid_EX;
  logic       reg_write_EX;

  modport master (
    output instr_ID, PC_ID, valid_ID, stall, flush, wb_en, wb_addr, wb_data,
    input  A_in, Imm_Data_EX, Sht_Data_EX, PC_EX, opcode_EX, ControlLines,
           sht_imm, rd_EX, valid_EX, reg_write_EX
  );

  modport slave (
    input  instr_ID, PC_ID, valid_ID, stall, flush, wb_en, wb_addr, wb_data,
    output A_in, Imm_Data_EX, Sht_Data_EX, PC_EX, opcode_EX, ControlLines,
           sht_imm, rd_EX, valid_EX, reg_write_EX
  );
endinterface

// File: rtl/id_ex_stage.sv
// Decode stage, 8x8 register file and ID/EX pipeline register with stall/flush.
// Optional macro ID_EX_FWD_EN: bypass a same-cycle writeback into the captured A_in.
module id_ex_stage (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_SLL  = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  localparam logic [3:0] CTRL_ADD    = 4'b0010;
  localparam logic [3:0] CTRL_SHL    = 4'b1000;
  localparam logic [3:0] CTRL_BUBBLE = 4'b0000;

  logic [7:0] regs [8];

  logic [1:0] op;
  logic [2:0] rd;
  logic [7:0] rd_val;

  logic [7:0] dec_a;
  logic [7:0] dec_imm;
  logic [7:0] dec_sht;
  logic [7:0] dec_pc;
  logic [1:0] dec_op;
  logic [3:0] dec_ctrl;
  logic       dec_sht_imm;
  logic [2:0] dec_rd;
  logic       dec_valid;
  logic       dec_reg_write;

  assign op = bus.instr_ID[7:6];
  assign rd = bus.instr_ID[5:3];

`ifdef ID_EX_FWD_EN
  assign rd_val = (bus.wb_en && (bus.wb_addr == rd)) ? bus.wb_data : regs[rd];
`else
  assign rd_val = regs[rd];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_en) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // An invalid slot decodes to the all-zero bubble so the register stage only has to pick a source.
  always_comb begin
    dec_a         = '0;
    dec_imm       = '0;
    dec_sht       = '0;
    dec_pc        = '0;
    dec_op        = '0;
    dec_ctrl      = CTRL_BUBBLE;
    dec_sht_imm   = 1'b0;
    dec_rd        = '0;
    dec_valid     = 1'b0;
    dec_reg_write = 1'b0;
    if (bus.valid_ID) begin
      dec_pc    = bus.PC_ID;
      dec_op    = op;
      dec_rd    = rd;
      dec_valid = 1'b1;
      case (op)
        OP_MOVI: begin
          dec_ctrl      = CTRL_ADD;
          dec_imm       = {5'b0, bus.instr_ID[2:0]};
          dec_reg_write = 1'b1;
        end
        OP_ADDI: begin
          dec_ctrl      = CTRL_ADD;
          dec_imm       = {5'b0, bus.instr_ID[2:0]};
          dec_a         = rd_val;
          dec_reg_write = 1'b1;
        end
        OP_SLL: begin
          dec_ctrl      = CTRL_SHL;
          dec_sht_imm   = 1'b1;
          dec_sht       = {5'b0, bus.instr_ID[2:0]};
          dec_a         = rd_val;
          dec_reg_write = 1'b1;
        end
        OP_JMP: begin
          dec_ctrl = CTRL_ADD;
          dec_imm  = {{2{bus.instr_ID[5]}}, bus.instr_ID[5:0]};
        end
        default: begin
          dec_ctrl = CTRL_BUBBLE;
        end
      endcase
    end
  end

  // Flush beats stall so a held slot can still be squashed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.flush) begin
      bus.A_in         <= '0;
      bus.Imm_Data_EX  <= '0;
      bus.Sht_Data_EX  <= '0;
      bus.PC_EX        <= '0;
      bus.opcode_EX    <= '0;
      bus.ControlLines <= CTRL_BUBBLE;
      bus.sht_imm      <= 1'b0;
      bus.rd_EX        <= '0;
      bus.valid_EX     <= 1'b0;
      bus.reg_write_EX <= 1'b0;
    end else if (!bus.stall) begin
      bus.A_in         <= dec_a;
      bus.Imm_Data_EX  <= dec_imm;
      bus.Sht_Data_EX  <= dec_sht;
      bus.PC_EX        <= dec_pc;
      bus.opcode_EX    <= dec_op;
      bus.ControlLines <= dec_ctrl;
      bus.sht_imm      <= dec_sht_imm;
      bus.rd_EX        <= dec_rd;
      bus.valid_EX     <= dec_valid;
      bus.reg_write_EX <= dec_reg_write;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expected EX contents, a monitor pops and compares.
// Expected forwarding result follows ID_EX_FWD_EN.
module tb_id_ex_stage;

  typedef struct packed {
    logic [7:0] a_in;
    logic [7:0] imm;
    logic [7:0] sht;
    logic [7:0] pc;
    logic [1:0] op;
    logic [3:0] ctrl;
    logic       sht_imm;
    logic [2:0] rd;
    logic       valid;
    logic       reg_write;
  } exp_t;

  logic clk;
  logic reset;
  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t  exp_q  [$];
  string name_q [$];
  int    checks   = 0;
  int    failures = 0;
  exp_t  bubble;
  exp_t  held;
  exp_t  e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] a, input logic [7:0] imm, input logic [7:0] sht,
                              input logic [7:0] pc, input logic [1:0] op, input logic [3:0] ctrl,
                              input logic si, input logic [2:0] rd, input logic rw);
    exp_t r;
    r.a_in = a; r.imm = imm; r.sht = sht; r.pc = pc; r.op = op; r.ctrl = ctrl;
    r.sht_imm = si; r.rd = rd; r.valid = 1'b1; r.reg_write = rw;
    return r;
  endfunction

  function automatic exp_t sample();
    exp_t r;
    r.a_in = bus.A_in; r.imm = bus.Imm_Data_EX; r.sht = bus.Sht_Data_EX; r.pc = bus.PC_EX;
    r.op = bus.opcode_EX; r.ctrl = bus.ControlLines; r.sht_imm = bus.sht_imm; r.rd = bus.rd_EX;
    r.valid = bus.valid_EX; r.reg_write = bus.reg_write_EX;
    return r;
  endfunction

  task automatic checkOutput(input exp_t expv, input string name);
    exp_t act;
    act = sample();
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (a,imm,sht,pc,op,ctrl,si,rd,v,rw)", name, act, expv);
    end
  endtask

  // One cycle: drive at the negedge, queue what EX must hold after the next posedge.
  task automatic applyStimulus(input logic [7:0] instr, input logic [7:0] pc, input logic v,
                               input logic st, input logic fl, input logic we,
                               input logic [2:0] wa, input logic [7:0] wd,
                               input exp_t expv, input string name);
    bus.instr_ID = instr; bus.PC_ID = pc; bus.valid_ID = v;
    bus.stall = st; bus.flush = fl;
    bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    exp_q.push_back(expv);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    bus.instr_ID = '0; bus.PC_ID = '0; bus.valid_ID = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front(), name_q.pop_front());
    end
  end

  initial begin
    bubble = '0;
    reset = 1'b1;
    idleInputs();
    #3;
    checkOutput(bubble, "reset_init");
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 8'h15, bubble, "wb_r2_bubble");
    applyStimulus(8'h55, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'h5A,
                  mk(8'h15, 8'h05, 8'h00, 8'h10, 2'b01, 4'b0010, 1'b0, 3'd2, 1'b1), "addi_r2");
    applyStimulus(8'h2F, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h21,
                  mk(8'h00, 8'h07, 8'h00, 8'h11, 2'b00, 4'b0010, 1'b0, 3'd5, 1'b1), "movi_r5");
    applyStimulus(8'h8B, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  mk(8'h21, 8'h00, 8'h03, 8'h12, 2'b10, 4'b1000, 1'b1, 3'd1, 1'b1), "sll_r1");
    applyStimulus(8'hFE, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  mk(8'h00, 8'hFE, 8'h00, 8'h40, 2'b11, 4'b0010, 1'b0, 3'd7, 1'b0), "jmp_neg2");
    applyStimulus(8'hDF, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  mk(8'h00, 8'h1F, 8'h00, 8'h41, 2'b11, 4'b0010, 1'b0, 3'd3, 1'b0), "jmp_pos31");
    held = mk(8'h5A, 8'h01, 8'h00, 8'h20, 2'b01, 4'b0010, 1'b0, 3'd3, 1'b1);
    applyStimulus(8'h59, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, held, "addi_r3");
    applyStimulus(8'h8B, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 8'h66, held, "stall_1");
    applyStimulus(8'h2F, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, held, "stall_2");
    applyStimulus(8'h8B, 8'h23, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, bubble, "flush_over_stall");
    applyStimulus(8'h70, 8'h23, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  mk(8'h66, 8'h00, 8'h00, 8'h23, 2'b01, 4'b0010, 1'b0, 3'd6, 1'b1), "write_during_stall");
    applyStimulus(8'h61, 8'h2F, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 8'h33, bubble, "invalid_bubble");
`ifdef ID_EX_FWD_EN
    e = mk(8'h7E, 8'h01, 8'h00, 8'h30, 2'b01, 4'b0010, 1'b0, 3'd4, 1'b1);
`else
    e = mk(8'h33, 8'h01, 8'h00, 8'h30, 2'b01, 4'b0010, 1'b0, 3'd4, 1'b1);
`endif
    applyStimulus(8'h61, 8'h30, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 8'h7E, e, "same_cycle_wb_r4");
    applyStimulus(8'h60, 8'h31, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  mk(8'h7E, 8'h00, 8'h00, 8'h31, 2'b01, 4'b0010, 1'b0, 3'd4, 1'b1), "r4_after_wb");
    applyStimulus(8'h55, 8'h32, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, bubble, "flush_valid");
    applyStimulus(8'h55, 8'h50, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  mk(8'h15, 8'h05, 8'h00, 8'h50, 2'b01, 4'b0010, 1'b0, 3'd2, 1'b1), "addi_r2_again");

    // Mid-cycle reset must clear outputs without a clock edge.
    idleInputs();
    #2;
    reset = 1'b1;
    #1;
    checkOutput(bubble, "async_reset_mid");
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(8'h58, 8'h60, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  mk(8'h00, 8'h00, 8'h00, 8'h60, 2'b01, 4'b0010, 1'b0, 3'd3, 1'b1), "r3_cleared");
    applyStimulus(8'h50, 8'h61, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  mk(8'h00, 8'h00, 8'h00, 8'h61, 2'b01, 4'b0010, 1'b0, 3'd2, 1'b1), "r2_cleared");
    idleInputs();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
